// File: rtl/snes_vector_monitor.sv
// Watches the synchronized A-bus for a two-byte CPU vector fetch (low byte, then high byte
// within a bounded window) and reports completed fetches as a registered hit pulse plus status.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | disarmed; target vector latched on exit
// WAIT_LO   | armed, waiting for the low-byte fetch of the target vector
// WAIT_HI   | low byte seen, waiting for high byte before the timer expires
// HOLD      | hit reported, waiting for host ack

module snes_vector_monitor #(
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] NMI_VEC = 16'hFFEA,
    parameter logic [7:0]  TIMEOUT = 8'd200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        event_latch,
    input  logic [15:0] addr,
    input  logic        arm,
    input  logic        vec_sel,
    input  logic        ack,
    output logic        hit,
    output logic        pending,
    output logic [7:0]  hit_count,
    output logic        overflow,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_LO = 2'd1,
        S_WAIT_HI = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] vec_q, vec_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  count_q, count_d;
    logic        hit_q, hit_d;
    logic        pending_q, pending_d;
    logic        overflow_q, overflow_d;

    logic [15:0] vec_hi;
    logic        ev_lo;
    logic        ev_hi;

    // 16-bit add wraps naturally, so a vector at FFFF pairs with 0000.
    assign vec_hi = vec_q + 16'd1;
    assign ev_lo  = event_latch && (addr == vec_q);
    assign ev_hi  = event_latch && (addr == vec_hi);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        timer_d    = timer_q;
        count_d    = count_q;
        hit_d      = 1'b0;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        if (!arm) begin
            state_d    = S_IDLE;
            timer_d    = 8'd0;
            count_d    = 8'd0;
            pending_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT_LO;
                    vec_d   = vec_sel ? NMI_VEC : RST_VEC;
                end
                S_WAIT_LO: begin
                    if (ev_lo) begin
                        state_d = S_WAIT_HI;
                        timer_d = TIMEOUT;
                    end
                end
                S_WAIT_HI: begin
                    // High-byte fetch wins even when the timer has just run out.
                    if (ev_hi) begin
                        state_d   = S_HOLD;
                        timer_d   = 8'd0;
                        hit_d     = 1'b1;
                        pending_d = 1'b1;
                        if (count_q != 8'hFF)
                            count_d = count_q + 8'd1;
                    end else if (ev_lo) begin
                        timer_d = TIMEOUT;
                    end else if (event_latch || (timer_q == 8'd0)) begin
                        state_d = S_WAIT_LO;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (ack) begin
                        state_d   = S_WAIT_LO;
                        pending_d = 1'b0;
                    end else if (ev_lo) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vec_q      <= RST_VEC;
            timer_q    <= 8'd0;
            count_q    <= 8'd0;
            hit_q      <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            hit_q      <= hit_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign hit       = hit_q;
    assign pending   = pending_q;
    assign hit_count = count_q;
    assign overflow  = overflow_q;
    assign state     = state_q;

endmodule
